// File: rtl/wb_writer_if.sv
// rtl/wb_writer_if.sv - write-back arbiter bus: WB results, load issue/response, register-file write port
interface wb_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                     alu_we;
    logic [ADDR_W-1:0]        alu_waddr;
    logic [DATA_W-1:0]        alu_wdata;
    logic                     ld_issue;
    logic [ADDR_W-1:0]        ld_issue_rd;
    logic                     ld_valid;
    logic [ADDR_W-1:0]        ld_rd;
    logic [DATA_W-1:0]        ld_data;
    logic                     ld_ready;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [(1<<ADDR_W)-1:0]   pending;

    modport master (
        output alu_we, alu_waddr, alu_wdata,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  we, waddr, wdata, pending
    );

    modport slave (
        input  alu_we, alu_waddr, alu_wdata,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output we, waddr, wdata, pending
    );
endinterface

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - register-file write-port arbiter merging WB results and buffered load responses
module wb_writer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_writer_if.slave  bus
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [NREG-1:0]   pending_q, kill_q;
    logic [NREG-1:0]   pending_n, kill_n;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              ld_ready;
    logic              alu_sel, fifo_empty, accept;
    logic              deq, byp, enq, ld_sel, ld_write;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Ready depends only on the occupancy register, so a full FIFO cannot accept even while draining.
    assign ld_ready    = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign bus.ld_ready = ld_ready;
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.pending = pending_q;

    // Pick the write source: ALU first, then FIFO head, then a bypassing response when the FIFO is empty.
    always_comb begin
        alu_sel    = bus.alu_we && (bus.alu_waddr != '0);
        fifo_empty = (count == '0);
        accept     = bus.ld_valid && ld_ready;
        deq        = !alu_sel && !fifo_empty;
        byp        = !alu_sel && fifo_empty && accept;
        enq        = accept && !byp;
        ld_sel     = deq || byp;
        sel_rd     = deq ? fifo_rd[rd_ptr]   : bus.ld_rd;
        sel_data   = deq ? fifo_data[rd_ptr] : bus.ld_data;
        // A killed or r0 load still uses up its slot but must not reach the register file.
        ld_write   = ld_sel && (sel_rd != '0) && !kill_q[sel_rd];
        wr_en      = alu_sel || ld_write;
        wr_addr    = alu_sel ? bus.alu_waddr : sel_rd;
        wr_data    = alu_sel ? bus.alu_wdata : sel_data;
    end

    // Next pending/kill: a younger ALU write kills the outstanding load; draining clears; issue sets.
    always_comb begin
        pending_n = pending_q;
        kill_n    = kill_q;
        if (alu_sel && pending_q[bus.alu_waddr])
            kill_n[bus.alu_waddr] = 1'b1;
        if (ld_sel && (sel_rd != '0)) begin
            pending_n[sel_rd] = 1'b0;
            kill_n[sel_rd]    = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_rd != '0))
            pending_n[bus.ld_issue_rd] = 1'b1;
    end

    // FIFO storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data[wr_ptr] <= bus.ld_data;
            fifo_rd[wr_ptr]   <= bus.ld_rd;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Pending and kill scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            kill_q    <= '0;
        end else begin
            pending_q <= pending_n;
            kill_q    <= kill_n;
        end
    end

    // Registered write port; address and data hold when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= wr_en;
            if (wr_en) begin
                waddr_q <= wr_addr;
                wdata_q <= wr_data;
            end
        end
    end

    // Decode must never issue a load to a register that still has one outstanding.
    assert property (@(posedge clk) disable iff (rst)
        !(bus.ld_issue && (bus.ld_issue_rd != '0) && pending_q[bus.ld_issue_rd]));
endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - directed self-checking bench for wb_writer
module tb_wb_writer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    wb_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    wb_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_we      = 1'b0;
        bus.alu_waddr   = '0;
        bus.alu_wdata   = '0;
        bus.ld_issue    = 1'b0;
        bus.ld_issue_rd = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = '0;
    endtask

    task automatic alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.alu_we    = 1'b1;
        bus.alu_waddr = a;
        bus.alu_wdata = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = a;
    endtask

    task automatic resp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = a;
        bus.ld_data  = d;
    endtask

    task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check({tag, "_we"}, 64'(bus.we), 64'd1);
        check({tag, "_waddr"}, 64'(bus.waddr), 64'(a));
        check({tag, "_wdata"}, 64'(bus.wdata), 64'(d));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_waddr", 64'(bus.waddr), 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        check("rst_pending", 64'(bus.pending), 64'd0);
        check("rst_ready", 64'(bus.ld_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 64'(bus.ld_ready), 64'd1);

        // ALU write, then ALU write to r0
        alu(5'd5, 32'hDEAD_BEEF);
        step();
        expect_write("alu", 5'd5, 32'hDEAD_BEEF);
        alu(5'd0, 32'h1);
        step();
        idle();
        check("alu_r0_we", 64'(bus.we), 64'd0);
        check("alu_r0_hold", 64'(bus.waddr), 64'd5);

        // bypass load
        issue(5'd7);
        step();
        idle();
        check("byp_pending_set", 64'(bus.pending), 64'h80);
        resp(5'd7, 32'h1234);
        step();
        idle();
        expect_write("byp", 5'd7, 32'h1234);
        check("byp_pending_clr", 64'(bus.pending), 64'd0);

        // contention and fill
        issue(5'd3);
        step();
        issue(5'd4);
        step();
        idle();
        check("cont_pending", 64'(bus.pending), 64'h18);
        for (int i = 0; i < 4; i++) begin
            alu(5'(10 + i), 32'(i + 100));
            bus.ld_valid = 1'b0;
            if (i == 0) resp(5'd3, 32'h33);
            if (i == 1) resp(5'd4, 32'h44);
            step();
            expect_write($sformatf("cont_alu%0d", i), 5'(10 + i), 32'(i + 100));
            if (i >= 1) check($sformatf("cont_full%0d", i), 64'(bus.ld_ready), 64'd0);
        end
        idle();
        resp(5'd0, 32'h55);
        #1;
        check("full_drain_ready", 64'(bus.ld_ready), 64'd0);
        step();
        expect_write("drain_r3", 5'd3, 32'h33);
        check("drain_r3_pending", 64'(bus.pending), 64'h10);
        check("drain_r3_ready", 64'(bus.ld_ready), 64'd1);
        step();
        idle();
        expect_write("drain_r4", 5'd4, 32'h44);
        check("drain_r4_pending", 64'(bus.pending), 64'd0);
        step();
        check("drain_r0_we", 64'(bus.we), 64'd0);
        check("drain_r0_hold", 64'(bus.wdata), 64'h44);
        step();
        check("drain_empty_we", 64'(bus.we), 64'd0);

        // kill
        issue(5'd9);
        step();
        idle();
        alu(5'd9, 32'hAA);
        step();
        idle();
        expect_write("kill_alu", 5'd9, 32'hAA);
        check("kill_pending", 64'(bus.pending), 64'h200);
        resp(5'd9, 32'hBB);
        step();
        idle();
        check("kill_we", 64'(bus.we), 64'd0);
        check("kill_wdata_hold", 64'(bus.wdata), 64'hAA);
        check("kill_pending_clr", 64'(bus.pending), 64'd0);
        issue(5'd9);
        step();
        idle();
        resp(5'd9, 32'hCC);
        step();
        idle();
        expect_write("kill_cleared", 5'd9, 32'hCC);

        // same-cycle issue and ALU write
        issue(5'd2);
        alu(5'd2, 32'h22);
        step();
        idle();
        expect_write("same_alu", 5'd2, 32'h22);
        check("same_pending", 64'(bus.pending), 64'h4);
        resp(5'd2, 32'h2222);
        step();
        idle();
        expect_write("same_load", 5'd2, 32'h2222);
        check("same_pending_clr", 64'(bus.pending), 64'd0);

        // reset mid-operation
        issue(5'd11);
        step();
        issue(5'd12);
        step();
        idle();
        alu(5'd20, 32'h1);
        resp(5'd11, 32'hB1);
        step();
        alu(5'd21, 32'h2);
        resp(5'd12, 32'hB2);
        step();
        check("mid_full_ready", 64'(bus.ld_ready), 64'd0);
        check("mid_pending", 64'(bus.pending), 64'h1800);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 64'(bus.we), 64'd0);
        check("mid_rst_pending", 64'(bus.pending), 64'd0);
        check("mid_rst_ready", 64'(bus.ld_ready), 64'd0);
        idle();
        step();
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 64'(bus.ld_ready), 64'd1);
        step();
        check("mid_no_stale0", 64'(bus.we), 64'd0);
        step();
        check("mid_no_stale1", 64'(bus.we), 64'd0);
        check("mid_rel_pending", 64'(bus.pending), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_writer.md
# wb_writer

Write-back arbiter that owns the single write port of the integer register file. It merges in-order ALU/WB-stage results with variable-latency load responses, and buffers load data that loses arbitration in a small FIFO. It also tracks registers with outstanding loads so decode can stall on them. Sits between the MEM/WB pipeline register, the load/store unit and the register file.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- FIFO_DEPTH, 2, load-response buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_we  in  1  WB-stage write valid; always accepted, never back-pressured
- alu_waddr  in  ADDR_W  WB-stage destination
- alu_wdata  in  DATA_W  WB-stage result
- ld_issue  in  1  load leaving decode; marks ld_issue_rd pending
- ld_issue_rd  in  ADDR_W  destination of issued load
- ld_valid  in  1  load response valid
- ld_rd  in  ADDR_W  load response destination
- ld_data  in  DATA_W  load response data
- ld_ready  out  1  response accepted when ld_valid && ld_ready
- we  out  1  register-file write enable (registered)
- waddr  out  ADDR_W  register-file write address (registered)
- wdata  out  DATA_W  register-file write data (registered)
- pending  out  2^ADDR_W  bit i set = load to register i outstanding (registered)

## Operation
- Per-cycle write source priority:
  1. ALU: alu_we && alu_waddr != 0.
  2. FIFO head, if the FIFO is non-empty.
  3. Bypass: accepted response, when the FIFO is empty.
- An accepted response not written this cycle is enqueued at the FIFO tail. Responses drain strictly in acceptance order.
- ld_ready = !rst && count < FIFO_DEPTH. Combinational from the count register only; it never depends on ld_valid.
- Pending tracking:
  - ld_issue with ld_issue_rd != 0 sets pending[rd].
  - When a load result is selected for the write port, pending[rd] clears.
  - Register 0 never goes pending.
- Kill:
  - An ALU write to register r while pending[r]=1 sets kill[r] (internal state). The ALU write is older in program order only if it is in the same cycle as the issue; see Timing.
  - A load result selected while kill[rd]=1 produces we=0 for that slot, clears both pending[rd] and kill[rd], and still consumes the slot.
- Loads to register 0 are accepted and consumed. They produce we=0.
- Protocol rule: decode never issues a load to a register whose pending bit is set. Behaviour on violation is undefined and flagged by an assertion.
- Counter/pointer arithmetic is modulo FIFO_DEPTH. The count width is clog2(FIFO_DEPTH)+1.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets: we=0, waddr=0, wdata=0, pending=0, kill=0, FIFO empty, ld_ready=0 while rst=1.
- Write latency, measured from the source cycle to we/waddr/wdata being valid:
  - ALU: 1 cycle.
  - Bypass load: 1 cycle.
  - Buffered load: 1 cycle after it reaches the FIFO head and wins arbitration.
- we is low in any cycle with no selected source. waddr and wdata then hold their previous values.
- Same-cycle events:
  - ld_issue and alu_we to the same r: the ALU write is older. pending[r] is set and kill[r] is not set.
  - Enqueue and dequeue in the same cycle: count is unchanged.
  - count == FIFO_DEPTH: ld_ready=0. No enqueue is possible even if a dequeue occurs that cycle; ready rises the following cycle.
  - Drain of r and ld_issue to r: excluded by the protocol rule.
- Continuous alu_we may starve the FIFO indefinitely. The ALU is never stalled.
- rst asserted mid-operation drops all buffered responses and pending/kill state immediately.

## Test plan
- ALU write alone: alu_we=1, alu_waddr=5, alu_wdata=0xDEAD_BEEF -> next cycle we=1, waddr=5, wdata=0xDEADBEEF. A write to register 0 instead yields we=0.
- Bypass load: ld_issue rd=7 -> pending[7]=1. Then ld_valid rd=7, data=0x1234 with no ALU write -> next cycle we=1, waddr=7, wdata=0x1234, and pending[7]=0 the same cycle.
- Contention and fill:
  - Stimulus: hold alu_we=1 for 4 cycles while sending loads rd=3 and rd=4.
  - Both loads are queued and ld_ready drops when count=2.
  - After alu_we drops, writes occur in order: r3, then r4, on consecutive cycles.
- Kill: issue load rd=9, then ALU write r9=0xAA, then load response rd=9 -> the response slot shows we=0. pending[9] and kill[9] clear, and the register file keeps 0xAA.
- Same-cycle issue and ALU write: ld_issue rd=2 together with alu_we r2 -> r2 is written by the ALU, and the later load response still writes r2 (no kill).
- Reset mid-operation: assert rst with a FIFO of 2 entries and pending bits set -> immediately we=0, pending=0, ld_ready=0. After release, ld_ready=1 and no stale write appears.
